// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB completion arbiter; `CDB_ARB_RR_EN selects round-robin priority (fixed priority otherwise)

package cdb_arbiter_pkg;

  // Result record exchanged between functional units and the CDB
  typedef struct packed {
    logic        valid;
    logic [31:0] value;
    logic        value_valid;
    logic [5:0]  dest_prf;
    logic [4:0]  rob_entry;
    logic [31:0] branch_address;
  } func_output_t;

endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = 4,
  parameter int CDB_WIDTH = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  func_output_t [NUM_FU-1:0]     fu_out,
  output logic         [NUM_FU-1:0]     fu_sel,
  output func_output_t [CDB_WIDTH-1:0]  cdb_out
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  func_output_t [CDB_WIDTH-1:0] cdb_d;
  func_output_t [CDB_WIDTH-1:0] cdb_q;
  logic [PW-1:0]                base_ptr;
  logic                         grant_en;

`ifdef CDB_ARB_RR_EN
  logic [PW-1:0] rr_q;
  logic [PW-1:0] rr_d;
`endif

  // Reset and flush both suppress every grant combinationally
  assign grant_en = reset & ~flush;

`ifdef CDB_ARB_RR_EN
  assign base_ptr = rr_q;
`else
  assign base_ptr = '0;
`endif

  // Walk the FUs from the highest-priority index, granting the first CDB_WIDTH requesters and packing them into slots in that order
  always_comb begin
    int            cnt;
    int            idx;
    logic [PW-1:0] idx_w;
    fu_sel = '0;
    cdb_d  = '0;
    cnt    = 0;
    idx    = 0;
    idx_w  = '0;
`ifdef CDB_ARB_RR_EN
    rr_d   = rr_q;
`endif
    for (int p = 0; p < NUM_FU; p++) begin
      idx = int'(base_ptr) + p;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      idx_w = idx[PW-1:0];
      if (grant_en && fu_out[idx_w].valid && (cnt < CDB_WIDTH)) begin
        fu_sel[idx_w] = 1'b1;
        for (int k = 0; k < CDB_WIDTH; k++) begin
          if (cnt == k) cdb_d[k] = fu_out[idx_w];
        end
        cnt = cnt + 1;
`ifdef CDB_ARB_RR_EN
        // The last grant seen in the walk fills the last slot; priority resumes just past it
        rr_d = (idx == NUM_FU - 1) ? '0 : idx_w + 1'b1;
`endif
      end
    end
  end

  // Register the broadcast; an idle or flushed cycle registers all-zero slots
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cdb_q <= '0;
    else        cdb_q <= cdb_d;
  end

`ifdef CDB_ARB_RR_EN
  // Rotating priority pointer, held when nothing is granted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
  end
`endif

  assign cdb_out = cdb_q;

endmodule
